// File: rtl/parallel_to_serial_converter_if.sv
// rtl/parallel_to_serial_converter_if.sv - load handshake and serial output bundle for the P2S converter
//
// Signals:
//   parallelDataIn [WIDTH]  word to serialize (producer -> converter)
//   loadValid               producer offers a word
//   loadReady               converter accepts a word this cycle
//   serialDataOut           current serial bit
//   serialValid             serialDataOut carries a valid bit
//   lastBit                 final bit of the current frame
//   busy                    frame in progress
// Modports: master = producer side, slave = converter side.
interface parallel_to_serial_converter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] parallelDataIn;
    logic             loadValid;
    logic             loadReady;
    logic             serialDataOut;
    logic             serialValid;
    logic             lastBit;
    logic             busy;

    modport master (
        output parallelDataIn, loadValid,
        input  loadReady, serialDataOut, serialValid, lastBit, busy
    );

    modport slave (
        input  parallelDataIn, loadValid,
        output loadReady, serialDataOut, serialValid, lastBit, busy
    );
endinterface

// File: rtl/parallel_to_serial_converter.sv
// rtl/parallel_to_serial_converter.sv - WIDTH-bit word to framed serial bit stream with zero-gap reload
//
// Parameters: WIDTH (>=2) word width, MSB_FIRST (1 = bit WIDTH-1 first, 0 = bit 0 first).
// Optional feature macro: P2S_PARITY_EN appends an even-parity bit to every frame.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    parallel_to_serial_converter_if.slave (load handshake in, serial stream out)
module parallel_to_serial_converter #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    parallel_to_serial_converter_if.slave   bus
);

`ifdef P2S_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    count_q, count_d;
    logic             accept;
    logic             data_bit;
`ifdef P2S_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Ready only when a new word can start next cycle: idle, or on the
    // final bit so the next frame follows without a gap.
    assign bus.loadReady = reset && ((state_q == IDLE) || (count_q == '0));
    assign accept        = bus.loadValid && bus.loadReady;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            count_q  <= '0;
`ifdef P2S_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            count_q  <= count_d;
`ifdef P2S_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        count_d  = count_q;
`ifdef P2S_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d  = bus.parallelDataIn;
                    count_d  = LAST_CNT;
                    state_d  = SHIFT;
`ifdef P2S_PARITY_EN
                    parity_d = ^bus.parallelDataIn;
`endif
                end
            end
            SHIFT: begin
                shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                count_d = count_q - CW'(1);
                if (count_q == '0) begin
                    if (accept) begin
                        shreg_d  = bus.parallelDataIn;
                        count_d  = LAST_CNT;
`ifdef P2S_PARITY_EN
                        parity_d = ^bus.parallelDataIn;
`endif
                    end else begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

`ifdef P2S_PARITY_EN
    // The parity bit occupies the count==0 slot after all data bits.
    assign bus.serialDataOut = (state_q == SHIFT) &&
                               ((count_q == '0) ? parity_q : data_bit);
`else
    assign bus.serialDataOut = (state_q == SHIFT) && data_bit;
`endif
    assign bus.serialValid = (state_q == SHIFT);
    assign bus.busy        = (state_q == SHIFT);
    assign bus.lastBit     = (state_q == SHIFT) && (count_q == '0);

endmodule

// File: tb/tb_parallel_to_serial_converter.sv
// tb/tb_parallel_to_serial_converter.sv - scoreboard bench for MSB-first and LSB-first converter instances
module tb_parallel_to_serial_converter;
    localparam int WIDTH = 8;
`ifdef P2S_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    parallel_to_serial_converter_if #(.WIDTH(WIDTH)) ifa ();
    parallel_to_serial_converter_if #(.WIDTH(WIDTH)) ifb ();

    parallel_to_serial_converter #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );
    parallel_to_serial_converter #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    int tests = 0;
    int fails = 0;

    // Each entry: {expected serial bit, expected lastBit}
    logic [1:0] qa[$];
    logic [1:0] qb[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: data bits in the configured order, then optional parity.
    task automatic push_frame(input logic [WIDTH-1:0] w);
        logic b_msb, b_lsb;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i < WIDTH) begin
                b_msb = w[WIDTH-1-i];
                b_lsb = w[i];
            end else begin
                b_msb = ^w;
                b_lsb = ^w;
            end
            qa.push_back({b_msb, (i == FRAME_LEN - 1)});
            qb.push_back({b_lsb, (i == FRAME_LEN - 1)});
        end
    endtask

    // Monitor: compare outputs against the scoreboard every cycle away from the edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("valid_msb", int'(ifa.serialValid), int'(qa.size() != 0));
            chk("busy_msb",  int'(ifa.busy),        int'(qa.size() != 0));
            chk("valid_lsb", int'(ifb.serialValid), int'(qb.size() != 0));
            if (qa.size() != 0) begin
                logic [1:0] e;
                e = qa.pop_front();
                chk("bit_msb",  int'(ifa.serialDataOut), int'(e[1]));
                chk("last_msb", int'(ifa.lastBit),       int'(e[0]));
            end else begin
                chk("idle_last_msb", int'(ifa.lastBit), 0);
            end
            if (qb.size() != 0) begin
                logic [1:0] e;
                e = qb.pop_front();
                chk("bit_lsb",  int'(ifb.serialDataOut), int'(e[1]));
                chk("last_lsb", int'(ifb.lastBit),       int'(e[0]));
            end else begin
                chk("idle_last_lsb", int'(ifb.lastBit), 0);
            end
        end
    end

    // One clock of stimulus, entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, output logic acc);
        logic exp_rdy;
        ifa.loadValid = v; ifa.parallelDataIn = d;
        ifb.loadValid = v; ifb.parallelDataIn = d;
        #1;
        exp_rdy = (qa.size() <= 1);
        chk("ready_msb", int'(ifa.loadReady), int'(exp_rdy));
        chk("ready_lsb", int'(ifb.loadReady), int'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        if (acc) push_frame(d);
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        logic acc = 1'b0;
        int n = 0;
        while (!acc && n < 40) begin
            cycle(1'b1, w, acc);
            n++;
        end
        chk("send_accepted", int'(acc), 1);
    endtask

    task automatic drain();
        logic acc;
        int n = 0;
        while (qa.size() != 0 && n < 40) begin
            cycle(1'b0, WIDTH'($urandom), acc);
            n++;
        end
        chk("drain_done", qa.size(), 0);
        ifa.loadValid = 1'b0; ifb.loadValid = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_data"},  int'(ifa.serialDataOut | ifb.serialDataOut), 0);
        chk({tag, "_valid"}, int'(ifa.serialValid | ifb.serialValid), 0);
        chk({tag, "_last"},  int'(ifa.lastBit | ifb.lastBit), 0);
        chk({tag, "_busy"},  int'(ifa.busy | ifb.busy), 0);
        chk({tag, "_ready"}, int'(ifa.loadReady | ifb.loadReady), 0);
    endtask

    initial begin
        logic acc;
        ifa.loadValid = 1'b0; ifa.parallelDataIn = '0;
        ifb.loadValid = 1'b0; ifb.parallelDataIn = '0;

        // Reset held for three cycles.
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_cleared("reset");
        end
        reset = 1'b1;

        // Directed frames, including a zero-gap pair.
        send(8'hA5); drain();
        send(8'h01); drain();
        send(8'hFF); send(8'h00); drain();
        send(8'h07); drain();
        send(8'h03); drain();

        // Reset mid-frame after three bits have been shown.
        send(8'hC3);
        cycle(1'b0, 8'h00, acc);
        cycle(1'b0, 8'h00, acc);
        #1;
        reset = 1'b0;
        #1;
        chk_cleared("async_reset");
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        chk_cleared("held_reset");
        reset = 1'b1;
        send(8'h3C); drain();

        // Random load traffic with noise on the data bus between accepts.
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), acc);
        drain();

        // Continuous loadValid: unbroken stream of random words.
        for (int i = 0; i < 6; i++) send(WIDTH'($urandom));
        drain();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
